// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state and owner encodings,
// default widths and a small owner helper.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    localparam int DATA_W_DEF = 32;
    localparam int BYTEEN_W   = DATA_W_DEF / 8;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_EXT : OWN_CPU;
    endfunction

endpackage

// File: rtl/dm_arb_hold.sv
// Request holding register for the arbiter: captures the granted request's
// address, byte enables, write data and PC on load; cleared by async reset.
module dm_arb_hold
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BE_W-1:0]   d_byteen,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [31:0]       d_pc,
    output logic [ADDR_W-1:0] q_addr,
    output logic [BE_W-1:0]   q_byteen,
    output logic [DATA_W-1:0] q_wdata,
    output logic [31:0]       q_pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_addr   <= '0;
            q_byteen <= '0;
            q_wdata  <= '0;
            q_pc     <= '0;
        end else if (load) begin
            q_addr   <= d_addr;
            q_byteen <= d_byteen;
            q_wdata  <= d_wdata;
            q_pc     <= d_pc;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory port between the CPU M-stage and an external requester.
// Fixed CPU priority by default; define DM_ARB_RR_EN for round-robin tie breaking.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W/8-1:0] cpu_byteen,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [31:0]         cpu_pc,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_done,
    output logic                cpu_stall,
    input  logic                ext_req,
    input  logic [ADDR_W-1:0]   ext_addr,
    input  logic [DATA_W/8-1:0] ext_byteen,
    input  logic [DATA_W-1:0]   ext_wdata,
    output logic [DATA_W-1:0]   ext_rdata,
    output logic                ext_done,
    output logic [ADDR_W-1:0]   m_data_addr,
    output logic [DATA_W/8-1:0] m_data_byteen,
    output logic [DATA_W-1:0]   m_data_wdata,
    input  logic [DATA_W-1:0]   m_data_rdata,
    output logic [31:0]         m_inst_addr,
    output logic [1:0]          dbg_state
);

    localparam int BE_W = DATA_W / 8;

    state_t            state, state_nxt;
    owner_t            owner, grant_own, idle_pick;
    logic              grant;
    logic              cpu_done_q, ext_done_q;
    logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;
    logic [ADDR_W-1:0] hold_addr;
    logic [BE_W-1:0]   hold_byteen;
    logic [DATA_W-1:0] hold_wdata;
    logic [31:0]       hold_pc;

`ifdef DM_ARB_RR_EN
    owner_t last_owner;

    // Starts as "EXT last" so the CPU takes the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      last_owner <= OWN_EXT;
        else if (grant) last_owner <= grant_own;
    end

    always_comb begin
        idle_pick = cpu_req ? OWN_CPU : OWN_EXT;
        if (cpu_req && ext_req) idle_pick = other_owner(last_owner);
    end
`else
    always_comb begin
        idle_pick = cpu_req ? OWN_CPU : OWN_EXT;
    end
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_own = owner;
        case (state)
            IDLE: begin
                if (cpu_req || ext_req) begin
                    grant     = 1'b1;
                    grant_own = idle_pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = RESP;
            RESP: begin
                // The completing owner sits out; only the other side can chain in.
                state_nxt = IDLE;
                if ((owner == OWN_CPU) ? ext_req : cpu_req) begin
                    grant     = 1'b1;
                    grant_own = other_owner(owner);
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            cpu_done_q  <= 1'b0;
            ext_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state      <= state_nxt;
            if (grant) owner <= grant_own;
            cpu_done_q <= (state == ISSUE) && (owner == OWN_CPU);
            ext_done_q <= (state == ISSUE) && (owner == OWN_EXT);
            if (cpu_done_q) cpu_rdata_q <= m_data_rdata;
            if (ext_done_q) ext_rdata_q <= m_data_rdata;
        end
    end

    dm_arb_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (grant),
        .d_addr   ((grant_own == OWN_CPU) ? cpu_addr   : ext_addr),
        .d_byteen ((grant_own == OWN_CPU) ? cpu_byteen : ext_byteen),
        .d_wdata  ((grant_own == OWN_CPU) ? cpu_wdata  : ext_wdata),
        .d_pc     ((grant_own == OWN_CPU) ? cpu_pc     : 32'h0),
        .q_addr   (hold_addr),
        .q_byteen (hold_byteen),
        .q_wdata  (hold_wdata),
        .q_pc     (hold_pc)
    );

    // Read data is live during the done cycle and held afterwards.
    assign cpu_rdata     = cpu_done_q ? m_data_rdata : cpu_rdata_q;
    assign ext_rdata     = ext_done_q ? m_data_rdata : ext_rdata_q;
    assign cpu_done      = cpu_done_q;
    assign ext_done      = ext_done_q;
    assign cpu_stall     = cpu_req && !cpu_done_q;
    assign m_data_addr   = hold_addr;
    assign m_data_wdata  = hold_wdata;
    assign m_data_byteen = (state == ISSUE) ? hold_byteen : '0;
    assign m_inst_addr   = hold_pc;
    assign dbg_state     = state;

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Sequencing controller that shares the single external data-memory port (m_data_addr / m_data_byteen / m_data_wdata / m_data_rdata) between the CPU memory stage and one external requester (DMA/debug).
- Each winning request is latched, issued for exactly one cycle, and completed with a registered read-data/done pulse.
- The CPU is stalled while its access is outstanding.
- Sits between the M-stage byte-enable/load-extension logic and the top-level memory port.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access pending; held with fields stable until cpu_done
- cpu_addr  in  ADDR_W  byte address
- cpu_byteen  in  DATA_W/8  write byte lanes; all-zero = read
- cpu_wdata  in  DATA_W  lane-aligned write data
- cpu_pc  in  32  PC of the issuing instruction
- cpu_rdata  out  DATA_W  raw word read; valid while cpu_done
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req && !cpu_done
- ext_req, ext_addr, ext_byteen, ext_wdata  in  (same widths)  external requester, same rules as CPU
- ext_rdata  out  DATA_W; ext_done  out  1  same rules as CPU
- m_data_addr  out  ADDR_W  memory address
- m_data_byteen  out  DATA_W/8  memory write enables
- m_data_wdata  out  DATA_W  memory write data
- m_data_rdata  in  DATA_W  valid in the cycle after the address cycle
- m_inst_addr  out  32  latched cpu_pc on CPU accesses, 0 on external accesses

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any request, pick a winner, latch its addr/byteen/wdata (and pc) into the holding register, record the owner -> ISSUE. Else stay in IDLE.
- ISSUE: drive m_data_* from the holding register. m_data_byteen is nonzero only in this state -> RESP.
- RESP: capture m_data_rdata into the owner's rdata register; pulse owner's done.
  - The completing owner is ineligible this cycle.
  - If the other requester is pending, latch it -> ISSUE; else -> IDLE.
- Outside ISSUE: m_data_byteen = 0; m_data_addr/m_data_wdata/m_inst_addr hold their last values.
- Arbitration, default: fixed priority, CPU wins ties.
- Reads and writes are sequenced identically. A write's done still returns m_data_rdata (pre-write word).
- No data manipulation: lane alignment and sign extension remain upstream/downstream.
- cpu_rdata/ext_rdata hold until that requester's next done.

## Timing
- Request sampled at edge E0 in IDLE -> address/byteen on port during cycle E0..E1 -> done asserted during E1..E2. Latency is 2 cycles from the sampling edge; the requester sees done in the 3rd cycle of request.
- Sustained throughput: one access per 2 cycles (ISSUE/RESP alternation) under contention.
- Simultaneous requests in IDLE: one winner; the loser is served in the ISSUE that immediately follows the winner's RESP.
- A request dropped before being granted is legal and is never issued. A request dropped after grant violates protocol; the access still completes.
- Reset (asynchronous, any state): FSM -> IDLE; owner cleared; all outputs 0 (m_data_*, m_inst_addr, both rdata, both done, cpu_stall follows cpu_req). An in-flight access produces no done.
- First edge after reset release behaves as IDLE.

## Configuration
- DM_ARB_RR_EN defined: round-robin. A last-owner flag is updated at each grant; on tie the requester not last granted wins. Reset value is "EXT last", so the CPU wins the first tie.
- Undefined: fixed CPU priority. The external requester can starve only under continuous CPU traffic (bounded by RESP ineligibility: after each CPU completion a pending ext request is granted).

## Structure
- Shared package dm_arb_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, RESP=2'd2
  - owner encoding OWN_CPU=1'b0, OWN_EXT=1'b1
  - BYTEEN_W = DATA_W/8
- One sub-module dm_arb_hold: the request holding register (addr, byteen, wdata, pc) with load enable and async clear.

## Test plan
- Read: after reset, CPU read addr 0x0000_0010, byteen 0, memory returns 0xDEAD_BEEF -> port addr 0x10 one cycle, cpu_done one cycle later, cpu_rdata = 0xDEADBEEF, cpu_stall high for exactly 2 cycles.
- Write: CPU sb to 0x13, byteen 4'b1000, wdata 0xAB00_0000 -> m_data_byteen = 1000 for exactly one cycle; m_inst_addr = cpu_pc 0x0000_3008.
- Tie: CPU and ext request in the same cycle (ext addr 0x40) -> CPU issues first, ext issues in the cycle after cpu_done; ext_done 2 cycles after cpu_done.
- Round-robin (DM_ARB_RR_EN): both requesting continuously for 6 accesses -> grants alternate CPU, EXT, CPU, EXT… Without the macro, a new CPU request arriving in the ext RESP cycle wins over an ext request.
- Reset mid-operation: assert reset during ISSUE of a write -> m_data_byteen drops to 0 asynchronously, no done pulse; after release a pending CPU read completes normally.
- Idle: no requests for 10 cycles -> byteen stays 0, no done pulses, FSM remains IDLE.
